// File: rtl/pingpong_row_buffer_if.sv
// Bus bundle for pingpong_row_buffer: write port, read port and
// bank-swap handshake. The compositor/fetch side drives through the
// master modport and the buffer itself sits on the slave modport.
interface pingpong_row_buffer_if #(
   parameter int ADDR_W = 8,
   parameter int W      = 16
) ();

   logic [ADDR_W-1:0] wr_addr;
   logic [W-1:0]      wr_data;
   logic              we;
   logic              wr_ready;
   logic [ADDR_W-1:0] rd_addr;
   logic              re;
   logic [W-1:0]      rd_data;
   logic              rd_valid;
   logic              swap_req;
   logic              swap_busy;
   logic              front_bank;

   modport master (
      output wr_addr, wr_data, we, rd_addr, re, swap_req,
      input  wr_ready, rd_data, rd_valid, swap_busy, front_bank
   );

   modport slave (
      input  wr_addr, wr_data, we, rd_addr, re, swap_req,
      output wr_ready, rd_data, rd_valid, swap_busy, front_bank
   );

endinterface

// File: rtl/pingpong_row_buffer.sv
// Double-banked scanline buffer. The compositor fills the back bank
// while the VGA fetch path reads the front bank; a swap request flips
// the banks and, when CLEAR_ON_SWAP is set, sweeps the new back bank
// to CLEAR_VALUE one word per cycle.
// Optional build macro PINGPONG_ROW_BUFFER_TRANSPARENT_EN: host writes
// skip any lane whose pixel equals CLEAR_VALUE (sprite transparency).
module pingpong_row_buffer #(
   parameter int PIX_BITS      = 4,
   parameter int PIX_PER_WORD  = 4,
   parameter int DEPTH         = 256,
   parameter int ADDR_W        = 8,
   parameter int CLEAR_ON_SWAP = 1,
   parameter int CLEAR_VALUE   = 0
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   pingpong_row_buffer_if.slave  bus
);

   localparam int W = PIX_BITS * PIX_PER_WORD;
   localparam logic [ADDR_W:0]     DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0]   LAST_C    = ADDR_W'(DEPTH - 1);
   localparam logic [PIX_BITS-1:0] CLEAR_PIX = PIX_BITS'(CLEAR_VALUE);
   localparam logic [W-1:0]        CLEAR_WORD = {PIX_PER_WORD{CLEAR_PIX}};

   typedef enum logic {READY, CLEAR} state_t;

   logic [W-1:0] mem [2][DEPTH];

   state_t            state_q, state_d;
   logic              frontBank_q, frontBank_d;
   logic [ADDR_W-1:0] clearCount_q, clearCount_d;
   logic [W-1:0]      rdData_q;
   logic              rdValid_q;

   logic                    backBank;
   logic                    memWe;
   logic [ADDR_W-1:0]       memAddr;
   logic [W-1:0]            memData;
   logic [PIX_PER_WORD-1:0] laneMask;

   assign backBank       = ~frontBank_q;
   assign bus.wr_ready   = (state_q == READY);
   assign bus.swap_busy  = (state_q == CLEAR);
   assign bus.front_bank = frontBank_q;
   assign bus.rd_data    = rdData_q;
   assign bus.rd_valid   = rdValid_q;

   // Control registers: state, active front bank and clear sweep position.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q      <= READY;
         frontBank_q  <= 1'b0;
         clearCount_q <= '0;
      end else begin
         state_q      <= state_d;
         frontBank_q  <= frontBank_d;
         clearCount_q <= clearCount_d;
      end
   end

   // Next-state: a swap in READY flips the banks and optionally starts a
   // sweep; in CLEAR the counter walks 0..DEPTH-1 and swap requests are dropped.
   always_comb begin
      state_d      = state_q;
      frontBank_d  = frontBank_q;
      clearCount_d = clearCount_q;
      case (state_q)
         READY: begin
            if (bus.swap_req) begin
               frontBank_d = ~frontBank_q;
               if (CLEAR_ON_SWAP != 0) begin
                  state_d      = CLEAR;
                  clearCount_d = '0;
               end
            end
         end
         CLEAR: begin
            if (clearCount_q == LAST_C) begin
               state_d      = READY;
               clearCount_d = '0;
            end else begin
               clearCount_d = clearCount_q + 1'b1;
            end
         end
         default: begin
            state_d = READY;
         end
      endcase
   end

   // Back-bank write source: host writes in READY, the sweep in CLEAR.
   // Writes are gated by reset so an aborted sweep stops on the reset edge.
   always_comb begin
      memWe    = 1'b0;
      memAddr  = bus.wr_addr;
      memData  = bus.wr_data;
      laneMask = '1;
      if (state_q == CLEAR) begin
         memWe   = Reset_n;
         memAddr = clearCount_q;
         memData = CLEAR_WORD;
      end else begin
         memWe = Reset_n && bus.we && ({1'b0, bus.wr_addr} < DEPTH_C);
`ifdef PINGPONG_ROW_BUFFER_TRANSPARENT_EN
         for (int i = 0; i < PIX_PER_WORD; i++) begin
            laneMask[i] = (bus.wr_data[i*PIX_BITS +: PIX_BITS] != CLEAR_PIX);
         end
`endif
      end
   end

   // Bank storage: lane-masked write into the current back bank, no reset.
   always_ff @(posedge Clk) begin
      if (memWe) begin
         for (int i = 0; i < PIX_PER_WORD; i++) begin
            if (laneMask[i]) begin
               mem[backBank][memAddr][i*PIX_BITS +: PIX_BITS] <= memData[i*PIX_BITS +: PIX_BITS];
            end
         end
      end
   end

   // Registered front-bank read; out-of-range addresses return zero.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         rdData_q  <= '0;
         rdValid_q <= 1'b0;
      end else begin
         rdValid_q <= bus.re;
         if (bus.re) begin
            if ({1'b0, bus.rd_addr} < DEPTH_C) begin
               rdData_q <= mem[frontBank_q][bus.rd_addr];
            end else begin
               rdData_q <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pingpong_row_buffer.sv
// Self-checking bench for pingpong_row_buffer. A full-size instance with
// clear-on-swap is checked through a read scoreboard; a DEPTH=200 instance
// without clearing exercises out-of-range addresses.
module tb_pingpong_row_buffer;

   logic clk;
   logic rstN;

   int checkCount = 0;
   int errorCount = 0;

   logic [15:0] expQ[$];
   logic [15:0] expWord;
   logic        monitorOn = 1'b0;

   pingpong_row_buffer_if #(.ADDR_W(8), .W(16)) bus ();
   pingpong_row_buffer_if #(.ADDR_W(8), .W(16)) bus2 ();

   pingpong_row_buffer #(
      .PIX_BITS(4), .PIX_PER_WORD(4), .DEPTH(256), .ADDR_W(8),
      .CLEAR_ON_SWAP(1), .CLEAR_VALUE(0)
   ) dut (
      .Clk(clk), .Reset_n(rstN), .bus(bus)
   );

   pingpong_row_buffer #(
      .PIX_BITS(4), .PIX_PER_WORD(4), .DEPTH(200), .ADDR_W(8),
      .CLEAR_ON_SWAP(0), .CLEAR_VALUE(0)
   ) dutSmall (
      .Clk(clk), .Reset_n(rstN), .bus(bus2)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit in case a bounded wait is miscounted.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One cycle of stimulus on the main bus, driven at the falling edge.
   task automatic applyStimulus(input logic doWe, input logic [7:0] wAddr, input logic [15:0] wData,
                                input logic doRe, input logic [7:0] rAddr, input logic [15:0] rExp,
                                input logic doSwap);
      @(negedge clk);
      bus.we       = doWe;
      bus.wr_addr  = wAddr;
      bus.wr_data  = wData;
      bus.re       = doRe;
      bus.rd_addr  = rAddr;
      bus.swap_req = doSwap;
      if (doRe) expQ.push_back(rExp);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0, 1'b0);
   endtask

   task automatic waitReady();
      for (int k = 0; k < 300; k++) begin
         idle();
         if (bus.wr_ready) break;
      end
      checkOutput("waitReady", bus.wr_ready, 1);
   endtask

   // Read scoreboard: every cycle rd_valid must match whether a read was
   // issued, and a valid read must return the queued expected word.
   always @(posedge clk) begin
      #1;
      if (monitorOn) begin
         checkOutput("rdValid", bus.rd_valid, expQ.size() != 0);
         if (expQ.size() != 0) begin
            expWord = expQ.pop_front();
            checkOutput("rdData", bus.rd_data, expWord);
         end
      end
   end

   initial begin
      int busyCount;
      int readyLow;
      logic [15:0] expTrans;

      rstN = 1'b0;
      bus.we = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.re = 0; bus.rd_addr = 0; bus.swap_req = 0;
      bus2.we = 0; bus2.wr_addr = 0; bus2.wr_data = 0; bus2.re = 0; bus2.rd_addr = 0; bus2.swap_req = 0;
      repeat (3) @(negedge clk);
      rstN = 1'b1;
      checkOutput("rstWrReady", bus.wr_ready, 1);
      checkOutput("rstSwapBusy", bus.swap_busy, 0);
      checkOutput("rstFront", bus.front_bank, 0);
      checkOutput("rstRdData", bus.rd_data, 0);
      checkOutput("rstRdValid", bus.rd_valid, 0);
      monitorOn = 1'b1;

      // Fill back bank 1, swap, then watch the 256-cycle sweep of bank 0
      // with a dropped write, an ignored swap and a read mid-sweep.
      applyStimulus(1'b1, 8'd5, 16'h1234, 1'b0, 8'd0, 16'h0, 1'b0);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0, 1'b1);
      busyCount = 0;
      readyLow  = 0;
      for (int k = 0; k < 300; k++) begin
         applyStimulus(k == 20, 8'd7, 16'hFFFF, k == 30, 8'd5, 16'h1234, k == 10);
         if (k == 12) checkOutput("swapIgnoredFront", bus.front_bank, 1);
         if (!bus.wr_ready) readyLow++;
         if (bus.swap_busy) busyCount++;
         else break;
      end
      checkOutput("clearBusyCycles", busyCount, 256);
      checkOutput("clearReadyLowCycles", readyLow, 256);
      checkOutput("frontAfterSwap", bus.front_bank, 1);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b1, 8'd5, 16'h1234, 1'b0);
      idle();

      // Swap back and read the freshly cleared bank 0.
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0, 1'b1);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b1, 8'd0, 16'h0, 1'b0);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b1, 8'd128, 16'h0, 1'b0);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b1, 8'd255, 16'h0, 1'b0);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b1, 8'd7, 16'h0, 1'b0);
      waitReady();
      checkOutput("frontSwapBack", bus.front_bank, 0);

      // Same-cycle swap, write and read on address 3.
      applyStimulus(1'b1, 8'd3, 16'h1111, 1'b0, 8'd0, 16'h0, 1'b0);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0, 1'b1);
      waitReady();
      applyStimulus(1'b1, 8'd200, 16'h7777, 1'b0, 8'd0, 16'h0, 1'b0);
      applyStimulus(1'b1, 8'd3, 16'hABCD, 1'b1, 8'd3, 16'h1111, 1'b1);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b1, 8'd3, 16'hABCD, 1'b0);
      checkOutput("frontSameCycle", bus.front_bank, 0);
      waitReady();

      // Reset in the middle of a sweep of bank 0 (at counter 100).
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0, 1'b1);
      for (int k = 0; k < 101; k++) begin
         idle();
         if (k == 50) checkOutput("midClearBusy", bus.swap_busy, 1);
         if (k == 100) rstN = 1'b0;
      end
      @(negedge clk);
      rstN = 1'b1;
      checkOutput("abortWrReady", bus.wr_ready, 1);
      checkOutput("abortSwapBusy", bus.swap_busy, 0);
      checkOutput("abortFront", bus.front_bank, 0);
      checkOutput("abortRdData", bus.rd_data, 0);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b1, 8'd3, 16'h0000, 1'b0);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b1, 8'd200, 16'h7777, 1'b0);
      idle();

      // Transparent lanes (macro build) versus plain overwrite.
`ifdef PINGPONG_ROW_BUFFER_TRANSPARENT_EN
      expTrans = 16'h5A5B;
`else
      expTrans = 16'h0A0B;
`endif
      applyStimulus(1'b1, 8'd9, 16'h5555, 1'b0, 8'd0, 16'h0, 1'b0);
      applyStimulus(1'b1, 8'd9, 16'h0A0B, 1'b0, 8'd0, 16'h0, 1'b0);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b0, 8'd0, 16'h0, 1'b1);
      applyStimulus(1'b0, 8'd0, 16'h0, 1'b1, 8'd9, expTrans, 1'b0);
      waitReady();
      idle();
      idle();
      checkOutput("sbDrained", expQ.size(), 0);

      // DEPTH=200 instance, no clear: out-of-range write dropped, read returns 0.
      @(negedge clk);
      bus2.we = 1'b1; bus2.wr_addr = 8'd50; bus2.wr_data = 16'h4321;
      @(negedge clk);
      bus2.wr_addr = 8'd250; bus2.wr_data = 16'h1234;
      @(negedge clk);
      bus2.we = 1'b0; bus2.swap_req = 1'b1;
      @(negedge clk);
      bus2.swap_req = 1'b0;
      checkOutput("smallFront", bus2.front_bank, 1);
      checkOutput("smallSwapBusy", bus2.swap_busy, 0);
      checkOutput("smallWrReady", bus2.wr_ready, 1);
      bus2.re = 1'b1; bus2.rd_addr = 8'd50;
      @(negedge clk);
      checkOutput("smallRdData50", bus2.rd_data, 16'h4321);
      checkOutput("smallRdValid50", bus2.rd_valid, 1);
      bus2.rd_addr = 8'd250;
      @(negedge clk);
      bus2.re = 1'b0;
      checkOutput("smallRdData250", bus2.rd_data, 16'h0000);
      checkOutput("smallRdValid250", bus2.rd_valid, 1);
      @(negedge clk);
      checkOutput("smallRdValidDrop", bus2.rd_valid, 0);

      monitorOn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
